acc_seq_ctrl: RTL

- Sequencer and register front-end for the matrix accelerator.
- Sits between the core's memory-mapped register bus and the accelerator's operand/result arrays and start strobe.
- Buffers the A and B operands, pulses start, waits a fixed latency, captures the result, then flags completion via status bit and interrupt.
- Lets software drive the accelerator without touching its datapath timing.

---
 rtl/acc_seq_ctrl_pkg.sv | 27 ++
 rtl/acc_seq_fsm.sv | 64 ++++++
 rtl/acc_seq_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/acc_seq_ctrl_pkg.sv
// Shared types and constants for the matrix accelerator sequencer:
// FSM state encoding, register offsets and register bit positions.
package acc_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        CAPTURE
    } state_t;

    localparam logic [11:0] CTRL_OFF   = 12'h000;
    localparam logic [11:0] STATUS_OFF = 12'h004;
    localparam logic [11:0] CYCLES_OFF = 12'h008;
    localparam logic [11:0] A_BASE     = 12'h100;
    localparam logic [11:0] B_BASE     = 12'h200;
    localparam logic [11:0] R_BASE     = 12'h300;

    // CTRL bits
    localparam int unsigned START_BIT  = 0;
    localparam int unsigned IRQ_EN_BIT = 1;
    // STATUS bits
    localparam int unsigned BUSY_BIT   = 0;
    localparam int unsigned DONE_BIT   = 1;
    localparam int unsigned ERR_BIT    = 2;

endpackage

// File: rtl/acc_seq_fsm.sv
// Start/wait/capture sequencer: pulses the accelerator start, waits LATENCY
// cycles, then strobes result capture and completion for one cycle.
module acc_seq_fsm
    import acc_seq_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic acc_start,
    output logic busy,
    output logic capture,
    output logic done_set
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_start <= 1'b0;
            busy      <= 1'b0;
            capture   <= 1'b0;
            done_set  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= PULSE;
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PULSE: begin
                    state     <= WAIT;
                    acc_start <= 1'b0;
                    cnt       <= CW'(LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= CAPTURE;
                        capture  <= 1'b1;
                        done_set <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CAPTURE: begin
                    state    <= IDLE;
                    capture  <= 1'b0;
                    done_set <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Register front-end for the matrix accelerator: operand/result buffers,
// CTRL/STATUS, and an optional busy-cycle counter (ACC_SEQ_CTRL_PERF_CNT_EN).
module acc_seq_ctrl
    import acc_seq_ctrl_pkg::*;
#(
    parameter int unsigned N_WORDS = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_req_i,
    input  logic                     reg_we_i,
    input  logic [11:0]              reg_addr_i,
    input  logic [31:0]              reg_wdata_i,
    output logic                     reg_gnt_o,
    output logic                     reg_rvalid_o,
    output logic [31:0]              reg_rdata_o,
    output logic [N_WORDS-1:0][31:0] acc_in_A_o,
    output logic [N_WORDS-1:0][31:0] acc_in_B_o,
    input  logic [N_WORDS-1:0][31:0] acc_out_i,
    output logic                     acc_start_o,
    output logic                     busy_o,
    output logic                     irq_o
);

    logic [N_WORDS-1:0][31:0] buf_a, buf_b, buf_r;
    logic        irq_en, done, err;
    logic        busy, capture, done_set;
    logic [9:0]  word;
    logic [5:0]  idx;
    logic        in_range;
    logic        sel_ctrl, sel_status, sel_cycles, sel_a, sel_b, sel_r;
    logic        wr, rd, start_wr, start_cmd, err_set;
    logic [31:0] rdata_next, cycles_rd;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^reg_addr_i[1:0];

    assign word       = reg_addr_i[11:2];
    assign idx        = reg_addr_i[7:2];
    assign in_range   = 32'(idx) < N_WORDS;
    assign sel_ctrl   = word == CTRL_OFF[11:2];
    assign sel_status = word == STATUS_OFF[11:2];
    assign sel_cycles = word == CYCLES_OFF[11:2];
    assign sel_a      = (reg_addr_i[11:8] == A_BASE[11:8]) && in_range;
    assign sel_b      = (reg_addr_i[11:8] == B_BASE[11:8]) && in_range;
    assign sel_r      = (reg_addr_i[11:8] == R_BASE[11:8]) && in_range;

    assign wr        = reg_req_i & reg_we_i;
    assign rd        = reg_req_i & ~reg_we_i;
    assign start_wr  = wr & sel_ctrl & reg_wdata_i[START_BIT];
    assign start_cmd = start_wr & ~busy;
    assign err_set   = busy & (start_wr | (wr & (sel_a | sel_b)));

    acc_seq_fsm #(.LATENCY(LATENCY)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start_cmd),
        .acc_start (acc_start_o),
        .busy      (busy),
        .capture   (capture),
        .done_set  (done_set)
    );

    // Completion and error set take priority over a same-cycle W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            buf_a  <= '0;
            buf_b  <= '0;
            buf_r  <= '0;
        end else begin
            if (wr && sel_ctrl)
                irq_en <= reg_wdata_i[IRQ_EN_BIT];
            if (done_set)
                done <= 1'b1;
            else if (start_cmd || (wr && sel_status && reg_wdata_i[DONE_BIT]))
                done <= 1'b0;
            if (err_set)
                err <= 1'b1;
            else if (wr && sel_status && reg_wdata_i[ERR_BIT])
                err <= 1'b0;
            for (int unsigned i = 0; i < N_WORDS; i++) begin
                if (wr && !busy && sel_a && (32'(idx) == i))
                    buf_a[i] <= reg_wdata_i;
                if (wr && !busy && sel_b && (32'(idx) == i))
                    buf_b[i] <= reg_wdata_i;
            end
            if (capture)
                buf_r <= acc_out_i;
        end
    end

`ifdef ACC_SEQ_CTRL_PERF_CNT_EN
    logic [31:0] cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycles <= '0;
        else if (wr && sel_cycles)
            cycles <= '0;
        else if (busy && (cycles != '1))
            cycles <= cycles + 32'd1;
    end

    assign cycles_rd = cycles;
`else
    assign cycles_rd = '0;
`endif

    always_comb begin
        rdata_next = '0;
        if (sel_ctrl) begin
            rdata_next[IRQ_EN_BIT] = irq_en;
        end else if (sel_status) begin
            rdata_next[BUSY_BIT] = busy;
            rdata_next[DONE_BIT] = done;
            rdata_next[ERR_BIT]  = err;
        end else if (sel_cycles) begin
            rdata_next = cycles_rd;
        end
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (32'(idx) == i) begin
                if (sel_a) rdata_next = buf_a[i];
                if (sel_b) rdata_next = buf_b[i];
                if (sel_r) rdata_next = buf_r[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= rd ? rdata_next : '0;
        end
    end

    assign reg_gnt_o  = reg_req_i;
    assign acc_in_A_o = buf_a;
    assign acc_in_B_o = buf_b;
    assign busy_o     = busy;
    assign irq_o      = done & irq_en;

endmodule
